sw_led_mmio: RTL and testbench
==============================

Name: sw_led_mmio

Overview:
- Memory-mapped GPIO responder on the miriscv core data bus; the core is the initiator.
- Debounces the 16 board switches and latches changed bits into an edge register, with an optional interrupt request.
- Holds the LED output register written by software.
- Sits between the core's data-bus decoder and the top-level sw_i/led_o pins.

Parameters:
- BASE_ADDR, 32'h8000_0000, base byte address of the 32-byte register window.
- DEBOUNCE_CYCLES, 16, cycles the synchronized switch vector must hold steady before it is accepted (minimum 2).
- BLINK_DIV, 25_000_000, half-period in cycles of the blink toggle (used only with LED_BLINK_EN).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous reset, active-high.
- req_i  in  1  bus request, qualifies all bus inputs for one cycle.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  4  byte enables for writes.
- addr_i  in  32  byte address.
- wdata_i  in  32  write data.
- rdata_o  out  32  read data.
- ack_o  out  1  response strobe, one cycle after a request.
- sw_i  in  16  raw asynchronous switch inputs.
- led_o  out  16  LED drive.
- irq_o  out  1  interrupt request, level.

Behaviour:
- Reset values: rdata_o=0, ack_o=0, led_o=0, irq_o=0, sw_val=0, sw_edge=0, irq_en=0, sync flops=0, debounce counter=0.
- Hit condition: hit = req_i && addr_i[31:5] == BASE_ADDR[31:5]. Register offset = addr_i[4:2].
- Ack timing: ack_o is asserted the cycle after every hit, for one cycle. A back-to-back request every cycle gives an ack every cycle. No ack for a non-hit.
- Read data: rdata_o is registered on a read hit and valid while ack_o=1. Otherwise it returns 0. Unmapped offsets read 0.
- Register map:
  - 0x00 SW_VAL (RO): {16'b0, debounced switches}.
  - 0x04 SW_EDGE (RW1C): bit set when the corresponding debounced bit changes. Writing 1 clears the bit; only bytes 0-1 are honoured per be_i.
  - 0x08 LED (RW): bits [15:0]; byte writes honour be_i[1:0]; upper bits read 0.
  - 0x0C IRQ_EN (RW): bit 0, written when be_i[0]=1.
  - 0x10 BLINK: see Optional Feature.
  - 0x14-0x1C: reserved; read 0, writes ignored.
- Writes to RO registers or unmapped offsets: ignored, still acked.
- Switch synchronizer: 2-flop synchronizer sw_i -> sw_sync. A candidate register tracks sw_sync.
- Debounce counter:
  - If sw_sync != candidate: counter <= 0 and candidate <= sw_sync.
  - Else if candidate != sw_val: counter increments. When counter == DEBOUNCE_CYCLES-1, sw_val <= candidate, sw_edge |= candidate ^ sw_val, and counter <= 0.
  - Else counter holds at 0.
- Debounce latency: a clean step on sw_i reaches SW_VAL exactly 2 + 1 + DEBOUNCE_CYCLES cycles later. Any bounce restarts the count.
- Simultaneous edge set and W1C clear on the same bit: set wins, and the bit stays 1.
- irq_o = irq_en && |sw_edge, registered, so it is one cycle after the cause.
- Reset mid-operation: all state returns to reset values. Any pending ack is dropped. A switch value already stable at sw_i is re-debounced after reset and sets its edge bits.
- LED output: led_o = LED register, registered (with LED_BLINK_EN, see below).

Optional Feature:
- Macro: SW_LED_MMIO_BLINK_EN.
- With the macro defined:
  - 0x10 BLINK is an RW 16-bit mask.
  - A free-running counter toggles blink_phase every BLINK_DIV cycles; both reset to 0.
  - led_o = LED ^ (BLINK & {16{blink_phase}}).
- Without the macro: 0x10 reads 0, writes are ignored, no counter is built, and led_o = LED.

Decomposition:
- Shared package sw_led_mmio_pkg holds:
  - register offset localparams (OFF_SW_VAL, OFF_SW_EDGE, OFF_LED, OFF_IRQ_EN, OFF_BLINK);
  - the width constant GPIO_W=16;
  - a typedef for the bus request struct (req, we, be, addr, wdata).
- One natural sub-module, sw_debounce: synchronizer, candidate, counter, sw_val, and a one-cycle change-mask output. It is parameterised by width and DEBOUNCE_CYCLES.

Test Plan (bench uses DEBOUNCE_CYCLES=4, BLINK_DIV=8):
- Reset: hold rst_i for 2 cycles -> led_o=0, irq_o=0, ack_o=0. Read 0x00 and 0x04 -> 0.
- Debounce: sw_i 0 -> 16'hAE4A held -> SW_VAL reads 32'h0000_AE4A starting 7 cycles after the step; SW_EDGE=16'hAE4A.
- Bounce: sw_i=16'hA800 for 2 cycles, back to 16'hAE4A for 1 cycle, then 16'hA800 held -> SW_VAL changes only once, to 16'hA800, with no transient value. SW_EDGE |= 16'h064A.
- IRQ and W1C:
  - Write IRQ_EN=1 with pending edges -> irq_o=1 the next cycle.
  - Write SW_EDGE=32'hFFFF -> irq_o=0.
  - Set sw_i=16'hFFFF and time a W1C to land in the same cycle as the edge update -> the new edge bits remain set.
- LED byte write:
  - Write LED=32'h0000_1234 with be=4'b0011 -> led_o=16'h1234.
  - Write 32'h0000_FF00 with be=4'b0010 -> led_o=16'hFF34.
  - Read back 0x08 -> 32'h0000_FF34 with ack exactly one cycle after req.
- Blink (macro defined): BLINK=16'h000F, LED=0 -> led_o alternates 16'h0000 and 16'h000F every 8 cycles. Without the macro, 0x10 reads 0 and led_o stays 0.

Source files
------------

// File: rtl/sw_led_mmio_pkg.sv
// sw_led_mmio_pkg: shared definitions for the switch/LED memory-mapped block.
//   GPIO_W           width of the switch and LED vectors
//   OFF_*            register word indices, compared against addr[4:2]
//   bus_req_t        one cycle of core data-bus request signals
//   be_lane_mask()   expands byte enables 0-1 into a 16-bit lane mask
package sw_led_mmio_pkg;

  localparam int GPIO_W = 16;

  localparam logic [2:0] OFF_SW_VAL  = 3'd0;  // byte offset 0x00
  localparam logic [2:0] OFF_SW_EDGE = 3'd1;  // byte offset 0x04
  localparam logic [2:0] OFF_LED     = 3'd2;  // byte offset 0x08
  localparam logic [2:0] OFF_IRQ_EN  = 3'd3;  // byte offset 0x0C
  localparam logic [2:0] OFF_BLINK   = 3'd4;  // byte offset 0x10

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

  // Only the two low byte lanes carry GPIO bits; upper lanes are ignored.
  function automatic logic [GPIO_W-1:0] be_lane_mask(input logic [3:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: 2-flop synchronizer followed by a stability debouncer.
//   clk_i     system clock
//   rst_i     synchronous reset, active-high
//   sw_i      raw asynchronous switch inputs [W-1:0]
//   sw_val_o  debounced switch vector [W-1:0]
//   change_o  bits that flip in sw_val_o; asserted for the single cycle in
//             which the new value is accepted, aligned with the sw_val update
// A new synchronized value must stay identical for DEBOUNCE_CYCLES cycles
// (minimum 2) before it is accepted; any change restarts the count.
module sw_debounce #(
  parameter int W               = 16,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] sw_i,
  output logic [W-1:0] sw_val_o,
  output logic [W-1:0] change_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]     sync1_q, sync1_d;
  logic [W-1:0]     sync2_q, sync2_d;
  logic [W-1:0]     cand_q,  cand_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [W-1:0]     val_q,   val_d;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    sync1_d  = sw_i;
    sync2_d  = sync1_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    val_d    = val_q;
    change_o = '0;

    if (sync2_q != cand_q) begin
      // Input moved: follow it and restart the stability count.
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cand_q != val_q) begin
      if (cnt_q == CNT_LAST) begin
        val_d    = cand_q;
        change_o = cand_q ^ val_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its source, independent of statement order.
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      val_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
    end
  end

  assign sw_val_o = val_q;

endmodule

// File: rtl/sw_led_mmio.sv
// sw_led_mmio: memory-mapped switch/LED responder on the miriscv data bus.
//   clk_i, rst_i           clock, synchronous active-high reset
//   req_i, we_i, be_i,     bus request (one cycle), write flag, byte enables,
//   addr_i, wdata_i        byte address, write data
//   rdata_o, ack_o         read data and response strobe, one cycle after a hit
//   sw_i                   raw switch inputs
//   led_o                  LED drive
//   irq_o                  level interrupt: IRQ_EN && any SW_EDGE bit
// Register window (32 bytes at BASE_ADDR):
//   0x00 SW_VAL RO, 0x04 SW_EDGE RW1C, 0x08 LED RW, 0x0C IRQ_EN RW,
//   0x10 BLINK RW (only with SW_LED_MMIO_BLINK_EN), 0x14-0x1C reserved.
// Build option: define SW_LED_MMIO_BLINK_EN to add the BLINK mask and a
// blink_phase toggling every BLINK_DIV cycles (BLINK_DIV >= 2);
// led_o = LED ^ (BLINK & blink_phase). Without it, led_o = LED.
module sw_led_mmio
  import sw_led_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h8000_0000,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter int          BLINK_DIV       = 25_000_000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              ack_o,
  input  logic [GPIO_W-1:0] sw_i,
  output logic [GPIO_W-1:0] led_o,
  output logic              irq_o
);

  bus_req_t          bus;
  logic              hit, wr_hit, rd_hit;
  logic [2:0]        off;
  logic [GPIO_W-1:0] lane_m, wr_bits, edge_clr;
  logic [GPIO_W-1:0] sw_val, sw_change;

  logic [GPIO_W-1:0] led_q,    led_d;
  logic [GPIO_W-1:0] edge_q,   edge_d;
  logic              irq_en_q, irq_en_d;
  logic              irq_q,    irq_d;
  logic              ack_q,    ack_d;
  logic [31:0]       rdata_q,  rdata_d;

  assign bus = '{req: req_i, we: we_i, be: be_i, addr: addr_i, wdata: wdata_i};

  assign hit     = bus.req && (bus.addr[31:5] == BASE_ADDR[31:5]);
  assign off     = bus.addr[4:2];
  assign wr_hit  = hit && bus.we;
  assign rd_hit  = hit && !bus.we;
  assign lane_m  = be_lane_mask(bus.be);
  assign wr_bits = bus.wdata[GPIO_W-1:0] & lane_m;

  sw_debounce #(
    .W              (GPIO_W),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .sw_i    (sw_i),
    .sw_val_o(sw_val),
    .change_o(sw_change)
  );

`ifdef SW_LED_MMIO_BLINK_EN
  localparam int BLINK_CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_CNT_W-1:0] BLINK_LAST = BLINK_CNT_W'(BLINK_DIV - 1);

  logic [GPIO_W-1:0]      blink_q,     blink_d;
  logic [BLINK_CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic                   blink_phase_q, blink_phase_d;
  logic [GPIO_W-1:0]      led_out_q,   led_out_d;

  always_comb begin
    blink_cnt_d   = blink_cnt_q + BLINK_CNT_W'(1);
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = !blink_phase_q;
    end
    led_out_d = led_q ^ (blink_q & {GPIO_W{blink_phase_q}});
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      blink_q       <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      led_out_q     <= '0;
    end else begin
      blink_q       <= blink_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      led_out_q     <= led_out_d;
    end
  end

  assign led_o = led_out_q;
`else
  assign led_o = led_q;
`endif

  always_comb begin
    led_d    = led_q;
    irq_en_d = irq_en_q;
    edge_clr = '0;
    rdata_d  = '0;
`ifdef SW_LED_MMIO_BLINK_EN
    blink_d  = blink_q;
`endif

    if (wr_hit) begin
      case (off)
        OFF_SW_EDGE: edge_clr = wr_bits;
        OFF_LED:     led_d    = (led_q & ~lane_m) | wr_bits;
        OFF_IRQ_EN:  if (bus.be[0]) irq_en_d = bus.wdata[0];
`ifdef SW_LED_MMIO_BLINK_EN
        OFF_BLINK:   blink_d  = (blink_q & ~lane_m) | wr_bits;
`endif
        default: ;
      endcase
    end

    if (rd_hit) begin
      case (off)
        OFF_SW_VAL:  rdata_d = {{(32-GPIO_W){1'b0}}, sw_val};
        OFF_SW_EDGE: rdata_d = {{(32-GPIO_W){1'b0}}, edge_q};
        OFF_LED:     rdata_d = {{(32-GPIO_W){1'b0}}, led_q};
        OFF_IRQ_EN:  rdata_d = {31'b0, irq_en_q};
`ifdef SW_LED_MMIO_BLINK_EN
        OFF_BLINK:   rdata_d = {{(32-GPIO_W){1'b0}}, blink_q};
`endif
        default:     rdata_d = '0;
      endcase
    end

    // Clear first, then OR in new changes: a set in the same cycle as a W1C wins.
    edge_d = (edge_q & ~edge_clr) | sw_change;
    ack_d  = hit;
    irq_d  = irq_en_q && (|edge_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      led_q    <= '0;
      edge_q   <= '0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      led_q    <= led_d;
      edge_q   <= edge_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;
  assign ack_o   = ack_q;
  assign irq_o   = irq_q;

  // Bus bits that no register uses (byte offset, upper lanes).
  logic unused_bits;
`ifdef SW_LED_MMIO_BLINK_EN
  assign unused_bits = ^{bus.addr[1:0], bus.be[3:2], bus.wdata[31:GPIO_W]};
`else
  localparam logic [31:0] BLINK_DIV_W = 32'(BLINK_DIV);
  assign unused_bits = ^{bus.addr[1:0], bus.be[3:2], bus.wdata[31:GPIO_W],
                         BLINK_DIV_W[0]};
`endif

endmodule

// File: tb/tb_sw_led_mmio.sv
// tb_sw_led_mmio: directed self-checking bench for sw_led_mmio with
// DEBOUNCE_CYCLES=4 and BLINK_DIV=8. Inputs change on the falling edge,
// outputs are sampled on the following falling edge.
module tb_sw_led_mmio;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        ack_o;
  logic [15:0] sw_i;
  logic [15:0] led_o;
  logic        irq_o;

  int n_checks = 0;
  int n_fail   = 0;

  sw_led_mmio #(
    .BASE_ADDR      (BASE),
    .DEBOUNCE_CYCLES(4),
    .BLINK_DIV      (8)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .req_i  (req_i),
    .we_i   (we_i),
    .be_i   (be_i),
    .addr_i (addr_i),
    .wdata_i(wdata_i),
    .rdata_o(rdata_o),
    .ack_o  (ack_o),
    .sw_i   (sw_i),
    .led_o  (led_o),
    .irq_o  (irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Both bus tasks are entered on a falling edge and return on the next one.
  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic acked);
    req_i = 1'b1; we_i = 1'b0; be_i = 4'b0000; addr_i = a; wdata_i = '0;
    @(posedge clk_i);
    @(negedge clk_i);
    req_i = 1'b0;
    acked = ack_o;
    d     = rdata_o;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, output logic acked);
    req_i = 1'b1; we_i = 1'b1; be_i = be; addr_i = a; wdata_i = d;
    @(posedge clk_i);
    @(negedge clk_i);
    req_i = 1'b0; we_i = 1'b0;
    acked = ack_o;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        a;
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; be_i = '0; addr_i = '0; wdata_i = '0; sw_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    n_checks++; if (led_o !== 16'h0) begin n_fail++; $display("FAIL reset_led: got %h want 0000", led_o); end
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq_o); end
    n_checks++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", ack_o); end
    bus_read(BASE + 32'h00, d, a);
    n_checks++; if (a !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL reset_sw_val: ack %b data %h want ack 1 data 0", a, d); end
    bus_read(BASE + 32'h04, d, a);
    n_checks++; if (a !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL reset_sw_edge: ack %b data %h want ack 1 data 0", a, d); end
  endtask

  // Clean step with back-to-back reads: accepted after 7 edges, so the read
  // sampled at edge 8 is the first to return the new value.
  task automatic test_debounce();
    logic [31:0] d, exp;
    logic        a;
    sw_i = 16'hAE4A;
    req_i = 1'b1; we_i = 1'b0; addr_i = BASE + 32'h00;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      exp = (k >= 8) ? 32'h0000_AE4A : 32'h0;
      n_checks++; if (ack_o !== 1'b1 || rdata_o !== exp) begin n_fail++; $display("FAIL debounce_step_%0d: ack %b data %h want ack 1 data %h", k, ack_o, rdata_o, exp); end
    end
    req_i = 1'b0;
    bus_read(BASE + 32'h04, d, a);
    n_checks++; if (d !== 32'h0000_AE4A) begin n_fail++; $display("FAIL debounce_edge: got %h want 0000ae4a", d); end
  endtask

  // A800 for 2 cycles, AE4A for 1, then A800 held. The glitch restarts the
  // count; acceptance lands on edge 10, seen by the read sampled at edge 11.
  task automatic test_bounce();
    logic [31:0] d, exp;
    logic        a;
    bus_write(BASE + 32'h04, 32'h0000_FFFF, 4'b0011, a);
    bus_read(BASE + 32'h04, d, a);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL bounce_pre_clear: got %h want 0", d); end
    sw_i = 16'hA800;
    req_i = 1'b1; we_i = 1'b0; addr_i = BASE + 32'h00;
    for (int k = 1; k <= 14; k++) begin
      if (k == 3) sw_i = 16'hAE4A;
      if (k == 4) sw_i = 16'hA800;
      @(posedge clk_i);
      @(negedge clk_i);
      exp = (k >= 11) ? 32'h0000_A800 : 32'h0000_AE4A;
      n_checks++; if (rdata_o !== exp) begin n_fail++; $display("FAIL bounce_val_%0d: got %h want %h", k, rdata_o, exp); end
    end
    req_i = 1'b0;
    bus_read(BASE + 32'h04, d, a);
    n_checks++; if (d !== 32'h0000_064A) begin n_fail++; $display("FAIL bounce_edge: got %h want 0000064a", d); end
  endtask

  task automatic test_irq_w1c();
    logic [31:0] d;
    logic        a;
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_disabled: got %b want 0", irq_o); end
    bus_write(BASE + 32'h0C, 32'h1, 4'b0001, a);
    @(negedge clk_i);
    n_checks++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_enable: got %b want 1", irq_o); end
    bus_write(BASE + 32'h04, 32'h0000_FFFF, 4'b0011, a);
    n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL w1c_ack: got %b want 1", a); end
    @(negedge clk_i);
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_after_w1c: got %b want 0", irq_o); end
    bus_read(BASE + 32'h0C, d, a);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL irq_en_read: got %h want 00000001", d); end
  endtask

  // Step to FFFF, then time a full W1C to the acceptance edge (edge 7).
  task automatic test_set_wins();
    logic [31:0] d;
    logic        a;
    sw_i = 16'hFFFF;
    repeat (6) @(negedge clk_i);
    bus_write(BASE + 32'h04, 32'h0000_FFFF, 4'b0011, a);
    bus_read(BASE + 32'h04, d, a);
    n_checks++; if (d !== 32'h0000_57FF) begin n_fail++; $display("FAIL set_wins_edge: got %h want 000057ff", d); end
    bus_read(BASE + 32'h00, d, a);
    n_checks++; if (d !== 32'h0000_FFFF) begin n_fail++; $display("FAIL set_wins_val: got %h want 0000ffff", d); end
    n_checks++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL set_wins_irq: got %b want 1", irq_o); end
  endtask

  task automatic test_led();
    logic [31:0] d;
    logic        a;
    bus_write(BASE + 32'h08, 32'h0000_1234, 4'b0011, a);
    @(negedge clk_i);
    n_checks++; if (led_o !== 16'h1234) begin n_fail++; $display("FAIL led_full: got %h want 1234", led_o); end
    bus_write(BASE + 32'h08, 32'h0000_FF00, 4'b0010, a);
    @(negedge clk_i);
    n_checks++; if (led_o !== 16'hFF34) begin n_fail++; $display("FAIL led_byte1: got %h want ff34", led_o); end
    bus_write(BASE + 32'h08, 32'hFFFF_0000, 4'b1100, a);
    @(negedge clk_i);
    n_checks++; if (led_o !== 16'hFF34) begin n_fail++; $display("FAIL led_upper_lanes: got %h want ff34", led_o); end
    bus_read(BASE + 32'h08, d, a);
    n_checks++; if (a !== 1'b1 || d !== 32'h0000_FF34) begin n_fail++; $display("FAIL led_read: ack %b data %h want ack 1 data 0000ff34", a, d); end
    @(negedge clk_i);
    n_checks++; if (ack_o !== 1'b0 || rdata_o !== 32'h0) begin n_fail++; $display("FAIL ack_single: ack %b data %h want ack 0 data 0", ack_o, rdata_o); end
  endtask

  task automatic test_blink();
    logic [31:0] d;
    logic        a;
    bus_write(BASE + 32'h08, 32'h0, 4'b0011, a);
    bus_write(BASE + 32'h10, 32'h0000_000F, 4'b0011, a);
    repeat (2) @(negedge clk_i);
`ifdef SW_LED_MMIO_BLINK_EN
    begin
      logic [15:0] prev;
      int          last, n_tr;
      bus_read(BASE + 32'h10, d, a);
      n_checks++; if (d !== 32'h0000_000F) begin n_fail++; $display("FAIL blink_read: got %h want 0000000f", d); end
      prev = led_o; last = -1; n_tr = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk_i);
        n_checks++; if (led_o !== 16'h0000 && led_o !== 16'h000F) begin n_fail++; $display("FAIL blink_value_%0d: got %h want 0000 or 000f", i, led_o); end
        if (led_o !== prev) begin
          if (last >= 0) begin
            n_checks++; if (i - last !== 8) begin n_fail++; $display("FAIL blink_period: got %0d want 8", i - last); end
          end
          last = i; n_tr++;
        end
        prev = led_o;
      end
      n_checks++; if (n_tr < 4) begin n_fail++; $display("FAIL blink_toggles: got %0d want at least 4", n_tr); end
    end
`else
    bus_read(BASE + 32'h10, d, a);
    n_checks++; if (a !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL blink_read: ack %b data %h want ack 1 data 0", a, d); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      n_checks++; if (led_o !== 16'h0) begin n_fail++; $display("FAIL blink_led_%0d: got %h want 0000", i, led_o); end
    end
`endif
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    logic        a;
    bus_write(BASE + 32'h1C, 32'hFFFF_FFFF, 4'b1111, a);
    n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL reserved_write_ack: got %b want 1", a); end
    bus_read(BASE + 32'h14, d, a);
    n_checks++; if (a !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL reserved_read: ack %b data %h want ack 1 data 0", a, d); end
    bus_write(BASE + 32'h00, 32'h0, 4'b1111, a);
    bus_read(BASE + 32'h00, d, a);
    n_checks++; if (d !== 32'h0000_FFFF) begin n_fail++; $display("FAIL ro_write_ignored: got %h want 0000ffff", d); end
    bus_read(BASE + 32'h20, d, a);
    n_checks++; if (a !== 1'b0 || d !== 32'h0) begin n_fail++; $display("FAIL miss_above: ack %b data %h want ack 0 data 0", a, d); end
    bus_write(32'h0000_0008, 32'h0000_00AA, 4'b0011, a);
    n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL miss_write_ack: got %b want 0", a); end
    bus_read(BASE + 32'h08, d, a);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL miss_write_ignored: got %h want 0", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic        a;
    bus_write(BASE + 32'h08, 32'h0000_5A5A, 4'b0011, a);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    req_i = 1'b1; we_i = 1'b0; addr_i = BASE + 32'h08;
    @(posedge clk_i);
    @(negedge clk_i);
    req_i = 1'b0;
    n_checks++; if (ack_o !== 1'b0 || rdata_o !== 32'h0) begin n_fail++; $display("FAIL mid_reset_ack: ack %b data %h want ack 0 data 0", ack_o, rdata_o); end
    n_checks++; if (led_o !== 16'h0 || irq_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset_out: led %h irq %b want led 0000 irq 0", led_o, irq_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    bus_read(BASE + 32'h00, d, a);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL post_reset_val0: got %h want 0", d); end
    repeat (10) @(negedge clk_i);
    bus_read(BASE + 32'h00, d, a);
    n_checks++; if (d !== 32'h0000_FFFF) begin n_fail++; $display("FAIL post_reset_val: got %h want 0000ffff", d); end
    bus_read(BASE + 32'h04, d, a);
    n_checks++; if (d !== 32'h0000_FFFF) begin n_fail++; $display("FAIL post_reset_edge: got %h want 0000ffff", d); end
    bus_read(BASE + 32'h0C, d, a);
    n_checks++; if (d !== 32'h0 || irq_o !== 1'b0) begin n_fail++; $display("FAIL post_reset_irq: irq_en %h irq %b want 0 and 0", d, irq_o); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_bounce();
    test_irq_w1c();
    test_set_wins();
    test_led();
    test_blink();
    test_unmapped();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
